// File: rtl/axis_pkg.sv
// Shared constants and word-layout helpers for the AXI4-Stream width packer.
// FIFO payload layout, MSB to LSB: {tdata, tkeep, tlast}.
package axis_pkg;

  localparam int IN_BYTES_DEF   = 4;
  localparam int RATIO_DEF      = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  function automatic int out_bytes(input int in_bytes, input int ratio);
    return in_bytes * ratio;
  endfunction

  function automatic int cnt_w(input int ratio);
    return $clog2(ratio);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // tdata (8 bits per byte) + tkeep (1 bit per byte) + tlast
  function automatic int word_w(input int ob);
    return 9 * ob + 1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is forced to zero while empty
// so the master-side outputs read as zero out of reset.
module axis_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count need one, and leaving the
  // array out of the reset tree lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so the order of statements inside the block cannot change behaviour.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axis_width_packer.sv
// AXI4-Stream upsizer: packs RATIO narrow beats (little-endian lanes) into one wide
// word, flushing early on TLAST, and buffers finished words in an output FIFO.
module axis_width_packer
  import axis_pkg::*;
#(
  parameter int IN_BYTES   = IN_BYTES_DEF,
  parameter int RATIO      = RATIO_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  input  logic [8*IN_BYTES-1:0]           s_tdata,
  input  logic                            s_tlast,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [8*IN_BYTES*RATIO-1:0]     m_tdata,
  output logic [IN_BYTES*RATIO-1:0]       m_tkeep,
  output logic                            m_tlast,
  output logic [lvl_w(FIFO_DEPTH)-1:0]    level
);

  localparam int OUT_BYTES = out_bytes(IN_BYTES, RATIO);
  localparam int CNT_W     = cnt_w(RATIO);
  localparam int WORD_W    = word_w(OUT_BYTES);
  localparam int IN_W      = 8 * IN_BYTES;
  localparam int OUT_W     = 8 * OUT_BYTES;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  logic                 run;
  logic [CNT_W-1:0]     beat_cnt;
  logic [OUT_W-1:0]     acc_data;
  logic [OUT_BYTES-1:0] acc_keep;
  logic [OUT_W-1:0]     merged_data;
  logic [OUT_BYTES-1:0] merged_keep;
  logic                 accept;
  logic                 complete;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WORD_W-1:0]    push_word;
  logic [WORD_W-1:0]    head_word;

  // Ready depends only on registered state, never on m_tready.
  assign s_tready = run && !fifo_full;
  assign accept   = s_tvalid && s_tready;
  assign complete = accept && ((beat_cnt == LAST_CNT) || s_tlast);

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    merged_data = acc_data;
    merged_keep = acc_keep;
    for (int k = 0; k < RATIO; k++) begin
      if (beat_cnt == CNT_W'(k)) begin
        merged_data[k*IN_W +: IN_W]         = s_tdata;
        merged_keep[k*IN_BYTES +: IN_BYTES] = '1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run      <= 1'b0;
      beat_cnt <= '0;
      acc_data <= '0;
      acc_keep <= '0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        if (complete) begin
          beat_cnt <= '0;
          acc_data <= '0;
          acc_keep <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          acc_data <= merged_data;
          acc_keep <= merged_keep;
        end
      end
    end
  end

  assign push_word = {merged_data, merged_keep, s_tlast};

  axis_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (complete),
    .wdata  (push_word),
    .pop    (m_tready),
    .rdata  (head_word),
    .level  (level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = head_word[WORD_W-1 -: OUT_W];
  assign m_tkeep  = head_word[OUT_BYTES:1];
  assign m_tlast  = head_word[0];

endmodule

// File: tb/tb_axis_width_packer.sv
// Directed and randomised checks for axis_width_packer with default parameters
// (4-byte beats, 4 beats per word, 4-word FIFO).
module tb_axis_width_packer;

  localparam int N_RAND = 1000;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } word_t;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         s_tvalid;
  logic         s_tready;
  logic [31:0]  s_tdata;
  logic         s_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tlast;
  logic [2:0]   level;

  int checks = 0;
  int errors = 0;

  axis_width_packer dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .level    (level)
  );

  always #5 clk_i = ~clk_i;

  // Offers one beat and returns #1 after the edge that accepted it.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    while (!s_tready && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!s_tready) begin
      checks++; errors++;
      $display("FAIL send_beat_timeout: s_tready=%b required 1", s_tready);
    end
    @(posedge clk_i); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  function automatic logic [127:0] bp_word(input int j);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) w[k*32 +: 32] = 32'(32'h01010101 * (4*j + k + 1));
    return w;
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
    #2;
    checks++;
    if ({s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata, level} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: s_tready=%b m_tvalid=%b m_tlast=%b keep=%h data=%h level=%0d required all 0",
               s_tready, m_tvalid, m_tlast, m_tkeep, m_tdata, level);
    end
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    checks++;
    if (s_tready !== 1'b0) begin
      errors++; $display("FAIL ready_before_run: got %b required 0", s_tready);
    end
    @(posedge clk_i); #1;
    checks++;
    if (s_tready !== 1'b1) begin
      errors++; $display("FAIL ready_after_run: got %b required 1", s_tready);
    end
  endtask

  task automatic test_full_word();
    m_tready = 1'b1;
    send_beat(32'h11111111, 1'b0);
    send_beat(32'h22222222, 1'b0);
    send_beat(32'h33333333, 1'b0);
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++; $display("FAIL full_word_premature: m_tvalid=%b required 0", m_tvalid);
    end
    send_beat(32'h44444444, 1'b0);
    checks++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast} !==
        {1'b1, 128'h44444444_33333333_22222222_11111111, 16'hFFFF, 1'b0}) begin
      errors++;
      $display("FAIL full_word: valid=%b data=%h keep=%h last=%b required 1 44444444333333332222222211111111 ffff 0",
               m_tvalid, m_tdata, m_tkeep, m_tlast);
    end
    @(posedge clk_i); #1;
    checks++;
    if (m_tvalid !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL full_word_pop: m_tvalid=%b level=%0d required 0 0", m_tvalid, level);
    end
  endtask

  task automatic test_early_flush();
    m_tready = 1'b1;
    send_beat(32'hAAAA0001, 1'b0);
    send_beat(32'hAAAA0002, 1'b1);
    checks++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast} !==
        {1'b1, 128'h00000000_00000000_AAAA0002_AAAA0001, 16'h00FF, 1'b1}) begin
      errors++;
      $display("FAIL early_flush: valid=%b data=%h keep=%h last=%b required 1 0000000000000000aaaa0002aaaa0001 00ff 1",
               m_tvalid, m_tdata, m_tkeep, m_tlast);
    end
    send_beat(32'h000000BB, 1'b1);
    checks++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast} !== {1'b1, 128'h0000_00BB, 16'h000F, 1'b1}) begin
      errors++;
      $display("FAIL flush_next_lane0: valid=%b data=%h keep=%h last=%b required 1 ...000000bb 000f 1",
               m_tvalid, m_tdata, m_tkeep, m_tlast);
    end
    @(posedge clk_i); #1;
    checks++;
    if (level !== 3'd0) begin
      errors++; $display("FAIL flush_drain: level=%0d required 0", level);
    end
  endtask

  task automatic test_backpressure();
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_beat(32'(32'h01010101 * (i + 1)), 1'b0);
      if (i % 4 == 3) begin
        checks++;
        if (level !== 3'(i / 4 + 1)) begin
          errors++; $display("FAIL bp_level_step: after beat %0d level=%0d required %0d", i + 1, level, i / 4 + 1);
        end
      end
    end
    checks++;
    if (s_tready !== 1'b0) begin
      errors++; $display("FAIL bp_ready_full: s_tready=%b required 0", s_tready);
    end
    s_tvalid = 1'b1;
    s_tdata  = 32'hDEADBEEF;
    repeat (3) begin
      @(posedge clk_i); #1;
      checks++;
      if (s_tready !== 1'b0 || level !== 3'd4 || m_tdata !== bp_word(0)) begin
        errors++;
        $display("FAIL bp_hold: s_tready=%b level=%0d data=%h required 0 4 %h", s_tready, level, m_tdata, bp_word(0));
      end
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    checks++;
    if (m_tdata !== bp_word(0)) begin
      errors++; $display("FAIL bp_pop0: data=%h required %h", m_tdata, bp_word(0));
    end
    for (int j = 0; j < 4; j++) begin
      @(posedge clk_i); #1;
      checks++;
      if (level !== 3'(3 - j)) begin
        errors++; $display("FAIL bp_drain_level: level=%0d required %0d", level, 3 - j);
      end
      if (j == 0) begin
        checks++;
        if (s_tready !== 1'b1) begin
          errors++; $display("FAIL bp_ready_return: s_tready=%b required 1", s_tready);
        end
      end
      if (j < 3) begin
        checks++;
        if (m_tdata !== bp_word(j + 1)) begin
          errors++; $display("FAIL bp_pop_order: word %0d data=%h required %h", j + 1, m_tdata, bp_word(j + 1));
        end
      end
    end
    m_tready = 1'b0;
  endtask

  task automatic test_simul_push_pop();
    m_tready = 1'b0;
    for (int k = 0; k < 4; k++) send_beat(32'hA0000000 | 32'(k), 1'b0);
    for (int k = 0; k < 3; k++) send_beat(32'hB0000000 | 32'(k), 1'b0);
    checks++;
    if (level !== 3'd1 || m_tdata !== 128'hA0000003_A0000002_A0000001_A0000000) begin
      errors++; $display("FAIL simul_pre: level=%0d data=%h required 1 a0000003a0000002a0000001a0000000", level, m_tdata);
    end
    s_tvalid = 1'b1;
    s_tdata  = 32'hB0000003;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    @(posedge clk_i); #1;
    s_tvalid = 1'b0;
    checks++;
    if (level !== 3'd1 || m_tdata !== 128'hB0000003_B0000002_B0000001_B0000000 || m_tkeep !== 16'hFFFF) begin
      errors++;
      $display("FAIL simul_push_pop: level=%0d data=%h keep=%h required 1 b0000003b0000002b0000001b0000000 ffff",
               level, m_tdata, m_tkeep);
    end
    @(posedge clk_i); #1;
    checks++;
    if (level !== 3'd0) begin
      errors++; $display("FAIL simul_drain: level=%0d required 0", level);
    end
    m_tready = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    m_tready = 1'b0;
    for (int k = 0; k < 4; k++) send_beat(32'hD0000000 | 32'(k), 1'b0);
    send_beat(32'hC0000001, 1'b0);
    send_beat(32'hC0000002, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({m_tvalid, level, s_tready, m_tdata, m_tkeep} !== '0) begin
      errors++;
      $display("FAIL reset_async: m_tvalid=%b level=%0d s_tready=%b data=%h keep=%h required all 0",
               m_tvalid, level, s_tready, m_tdata, m_tkeep);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    checks++;
    if (s_tready !== 1'b0) begin
      errors++; $display("FAIL reset_release_ready: s_tready=%b required 0", s_tready);
    end
    @(posedge clk_i); #1;
    checks++;
    if (s_tready !== 1'b1) begin
      errors++; $display("FAIL reset_run_ready: s_tready=%b required 1", s_tready);
    end
    m_tready = 1'b1;
    for (int k = 0; k < 4; k++) send_beat(32'hE0000000 | 32'(k), 1'b0);
    checks++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast} !==
        {1'b1, 128'hE0000003_E0000002_E0000001_E0000000, 16'hFFFF, 1'b0}) begin
      errors++;
      $display("FAIL reset_clean_word: valid=%b data=%h keep=%h last=%b required 1 e0000003e0000002e0000001e0000000 ffff 0",
               m_tvalid, m_tdata, m_tkeep, m_tlast);
    end
    @(posedge clk_i); #1;
    checks++;
    if (level !== 3'd0) begin
      errors++; $display("FAIL reset_drain: level=%0d required 0", level);
    end
  endtask

  task automatic test_random();
    word_t        exp_q[$];
    word_t        exp_w;
    int           sent = 0;
    int           cyc = 0;
    int           built = 0;
    int           popped = 0;
    int           m_cnt = 0;
    logic [127:0] m_data = '0;
    logic [15:0]  m_keep = '0;
    logic         acc;
    logic         pop;
    logic         prev_stall = 1'b0;
    word_t        prev_w = '0;

    s_tvalid = 1'b0;
    while ((sent < N_RAND || exp_q.size() != 0 || level != 3'd0) && cyc < 20000) begin
      if (prev_stall) begin
        checks++;
        if ({m_tdata, m_tkeep, m_tlast} !== prev_w) begin
          errors++;
          $display("FAIL rand_stall_stable: data=%h keep=%h last=%b required %h %h %b",
                   m_tdata, m_tkeep, m_tlast, prev_w.data, prev_w.keep, prev_w.last);
        end
      end
      if (!s_tvalid && sent < N_RAND && $urandom_range(0, 3) != 0) begin
        s_tvalid = 1'b1;
        s_tdata  = $urandom;
        s_tlast  = (sent == N_RAND - 1) || ($urandom_range(0, 7) == 0);
      end
      m_tready = (sent >= N_RAND) ? 1'b1 : ($urandom_range(0, 2) != 0);
      acc = s_tvalid && s_tready;
      pop = m_tvalid && m_tready;
      if (pop) begin
        checks++;
        popped++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra_word: data=%h required no word", m_tdata);
        end else begin
          exp_w = exp_q.pop_front();
          if ({m_tdata, m_tkeep, m_tlast} !== exp_w) begin
            errors++;
            $display("FAIL rand_word: data=%h keep=%h last=%b required %h %h %b",
                     m_tdata, m_tkeep, m_tlast, exp_w.data, exp_w.keep, exp_w.last);
          end
        end
      end
      if (acc) begin
        m_data[m_cnt*32 +: 32] = s_tdata;
        m_keep[m_cnt*4 +: 4]   = 4'hF;
        if (m_cnt == 3 || s_tlast) begin
          exp_q.push_back('{data: m_data, keep: m_keep, last: s_tlast});
          built++;
          m_cnt  = 0;
          m_data = '0;
          m_keep = '0;
        end else begin
          m_cnt++;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_w     = {m_tdata, m_tkeep, m_tlast};
      @(posedge clk_i); #1;
      cyc++;
      if (acc) begin
        s_tvalid = 1'b0;
        sent++;
      end
    end
    checks++;
    if (cyc >= 20000 || exp_q.size() != 0 || level !== 3'd0 || popped != built) begin
      errors++;
      $display("FAIL rand_complete: cycles=%0d pending=%0d level=%0d popped=%0d required <20000 0 0 %0d",
               cyc, exp_q.size(), level, popped, built);
    end
    m_tready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_early_flush();
    test_backpressure();
    test_simul_push_pop();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
